pool1_fmap_streamer: RTL and testbench
======================================

// Module: pool1_fmap_streamer
// PURPOSE
//  Reader side of the pool-1 output array. Snapshots the full CHANNELS x ROWS x COLS
//  binary pooled feature-map array on a start pulse, then streams it out one row per beat.
//  The stream uses a valid/ready handshake, with row, channel and frame markers.
//  Feeds the next layer, or an off-chip link, that cannot take the whole array in parallel.
// PARAMETERS
//  CHANNELS  18  number of pooled feature maps
//  ROWS      12  rows per pooled map
//  COLS      12  columns per pooled map; also the beat width
// PORTS
//  clk        in   1                    sole clock, all logic on posedge
//  rst        in   1                    synchronous, active-high reset
//  fmaps_in   in   [CHANNELS][ROWS][COLS]  pooled maps, 1 bit per pixel, sampled on start
//  start      in   1                    1-cycle request to snapshot and stream a frame
//  busy       out  1                    high from the snapshot cycle until the final handshake
//  out_valid  out  1                    beat valid
//  out_ready  in   1                    downstream accepts the beat
//  out_data   out  COLS                 out_data[c] = snapshot[chan][row][c]
//  out_chan   out  $clog2(CHANNELS)     channel index of the current beat
//  out_row    out  $clog2(ROWS)         row index of the current beat
//  out_eoc    out  1                    beat is row ROWS-1 (end of channel)
//  out_eof    out  1                    beat is channel CHANNELS-1, row ROWS-1 (end of frame)
//  done       out  1                    1-cycle pulse after the final beat handshake
// BEHAVIOUR
//  Reset values
//  - Outputs: busy=0, out_valid=0, done=0; out_data, out_chan, out_row, out_eoc, out_eof = 0.
//  - State: FSM=IDLE, chan=0, row=0. The snapshot register is not reset.
//  FSM states: IDLE, SEND, FIN.
//  - IDLE: start=1 copies fmaps_in into the snapshot, clears chan/row, sets busy, goes to SEND.
//    The first beat (chan 0, row 0) is valid in the cycle after start (latency 1).
//  - SEND: out_valid=1. Handshake = out_valid & out_ready.
//    On a handshake: row++. At row==ROWS-1, row wraps to 0 and chan++.
//    The handshake on the eof beat goes to FIN and drops out_valid and busy on the next edge.
//  - FIN: done=1 for exactly one cycle, then IDLE. A start seen in FIN is ignored.
//  Handshake rules
//  - While out_valid & !out_ready: out_data, out_chan, out_row, out_eoc and out_eof hold stable.
//  - out_valid never deasserts without a handshake, except on reset.
//  - out_valid does not depend combinationally on out_ready.
//  - With out_ready held high, one beat per cycle: CHANNELS*ROWS beats (216) on consecutive cycles.
//  Data
//  - out_data is driven from the snapshot, so fmaps_in may change freely after start.
//  - Beat order is channel-major, then row-major.
//  Boundary conditions
//  - start while busy or in FIN: ignored; no re-snapshot, no counter change.
//  - out_ready high in IDLE: no effect.
//  - rst mid-frame: next edge returns to IDLE with out_valid=0 and no done pulse.
//    The partial frame is abandoned.
//  - rst and start in the same cycle: reset wins.
//  - start in the cycle immediately after done: accepted as a normal new frame.
//  - Counter widths: chan never exceeds CHANNELS-1, row never exceeds ROWS-1.
// TESTING
//  1. Reset, then start with fmaps_in[c][r][k] = ((c+r+k)%3==0), out_ready=1
//     -> 216 consecutive beats, each matching the pattern; eoc on every 12th beat;
//        eof only on beat 215; done one cycle after it.
//  2. Same frame with out_ready toggling randomly (~50%)
//     -> identical beat sequence; all outputs stable during each stall; no beat lost or duplicated.
//  3. Change fmaps_in to all-ones the cycle after start
//     -> streamed data still equals the original snapshot.
//  4. Pulse start at beat 40, and again in the FIN cycle
//     -> both ignored; exactly 216 beats and one done pulse.
//  5. Assert rst at beat 100 (chan 8, row 4)
//     -> out_valid=0 and busy=0 next cycle, no done; a following start streams from chan 0, row 0.
//  6. Stall out_ready low for 50 cycles on beat 11 (chan 0, row 11)
//     -> out_eoc=1, out_data and out_chan/out_row held; on release the next beat is chan 1, row 0.

Source files
------------

// File: rtl/pool1_fmap_streamer_if.sv
// Row-beat stream carrying one pooled-map row per handshake, with channel/row
// position and end-of-channel / end-of-frame markers.
interface pool1_fmap_streamer_if #(
  parameter int CHANNELS = 18,
  parameter int ROWS     = 12,
  parameter int COLS     = 12
);
  localparam int CW = $clog2(CHANNELS);
  localparam int RW = $clog2(ROWS);

  logic            out_valid;
  logic            out_ready;
  logic [COLS-1:0] out_data;
  logic [CW-1:0]   out_chan;
  logic [RW-1:0]   out_row;
  logic            out_eoc;
  logic            out_eof;

  modport master (
    output out_valid, out_data, out_chan, out_row, out_eoc, out_eof,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_chan, out_row, out_eoc, out_eof,
    output out_ready
  );
endinterface

// File: rtl/pool1_fmap_streamer.sv
// Snapshots the pooled feature-map array on start and streams it out one row per
// beat, channel-major, over a valid/ready handshake.
module pool1_fmap_streamer #(
  parameter int CHANNELS = 18,
  parameter int ROWS     = 12,
  parameter int COLS     = 12
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CHANNELS-1:0][ROWS-1:0][COLS-1:0] fmaps_in,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  pool1_fmap_streamer_if.master                  stream
);
  localparam int CW = $clog2(CHANNELS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] CHAN_LAST = CW'(CHANNELS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t                                state, state_nxt;
  logic [CW-1:0]                         chan;
  logic [RW-1:0]                         row;
  logic [CHANNELS-1:0][ROWS-1:0][COLS-1:0] snap;
  logic                                  take, hs, last_row, last_beat;

  assign take      = (state == IDLE) && start;
  assign hs        = (state == SEND) && stream.out_ready;
  assign last_row  = (row == ROW_LAST);
  assign last_beat = last_row && (chan == CHAN_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND:    if (hs && last_beat) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final beat wraps chan back to 0 so the counters never leave range.
  always_ff @(posedge clk) begin
    if (rst || take) begin
      chan <= '0;
      row  <= '0;
    end else if (hs) begin
      if (last_row) begin
        row  <= '0;
        chan <= last_beat ? '0 : chan + CW'(1);
      end else begin
        row <= row + RW'(1);
      end
    end
  end

  // NOTE: the snapshot is pure datapath; it is only read while in SEND, after a
  // load, so it needs no reset and costs no reset fan-out.
  always_ff @(posedge clk) begin
    if (take) snap <= fmaps_in;
  end

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    stream.out_valid = 1'b0;
    stream.out_data  = '0;
    stream.out_chan  = '0;
    stream.out_row   = '0;
    stream.out_eoc   = 1'b0;
    stream.out_eof   = 1'b0;
    case (state)
      SEND: begin
        busy             = 1'b1;
        stream.out_valid = 1'b1;
        stream.out_data  = snap[chan][row];
        stream.out_chan  = chan;
        stream.out_row   = row;
        stream.out_eoc   = last_row;
        stream.out_eof   = last_beat;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pool1_fmap_streamer.sv
// Self-checking bench for pool1_fmap_streamer: reset/idle vector table plus whole
// frames checked beat by beat against an index-based reference of the snapshot.
module tb_pool1_fmap_streamer;
  localparam int CH    = 18;
  localparam int RO    = 12;
  localparam int CO    = 12;
  localparam int CW    = $clog2(CH);
  localparam int RW    = $clog2(RO);
  localparam int NBEAT = CH * RO;

  logic clk, rst, start, busy, done;
  logic [CH-1:0][RO-1:0][CO-1:0] fmaps_in, golden;

  pool1_fmap_streamer_if #(.CHANNELS(CH), .ROWS(RO), .COLS(CO)) sif ();

  pool1_fmap_streamer #(.CHANNELS(CH), .ROWS(RO), .COLS(CO)) dut (
    .clk      (clk),
    .rst      (rst),
    .fmaps_in (fmaps_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .stream   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  string cur   = "init";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", cur, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern();
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < RO; r++)
        for (int k = 0; k < CO; k++)
          golden[c][r][k] = ((c + r + k) % 3 == 0);
    fmaps_in = golden;
  endtask

  // One frame: start, then per cycle compare the visible beat with the reference
  // beat selected by the count of completed handshakes.
  task automatic run_frame(input int ready_pct, input int stall_beat, input int stall_len,
                           input int poke_beat, input bit poke_fin, input bit ones_after,
                           input int abort_beat);
    int beat = 0;
    int cyc = 0;
    int stalled = 0;
    int c, r;
    bit poked = 1'b0;
    bit prev_stall = 1'b0;
    logic [CO-1:0] p_data;
    logic [CW-1:0] p_chan;
    logic [RW-1:0] p_row;
    logic          p_eoc, p_eof;
    start = 1'b1;
    sif.out_ready = 1'b0;
    tick();
    start = 1'b0;
    if (ones_after) fmaps_in = '1;
    check("busy_after_start", busy, 1);
    while (beat < NBEAT && cyc < 20000) begin
      if (beat == abort_beat) begin
        rst = 1'b1;
        sif.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", sif.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_row", sif.out_row, 0);
        check("abort_chan", sif.out_chan, 0);
        tick();
        check("abort_no_done", done, 0);
        check("abort_idle", sif.out_valid, 0);
        return;
      end
      if (beat == stall_beat && stalled < stall_len) begin
        sif.out_ready = 1'b0;
        stalled++;
      end else begin
        sif.out_ready = ($urandom_range(99) < ready_pct);
      end
      if (beat == poke_beat && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      c = beat / RO;
      r = beat % RO;
      check("valid", sif.out_valid, 1);
      check("busy", busy, 1);
      check("done_early", done, 0);
      if (prev_stall) begin
        check("hold_data", sif.out_data, p_data);
        check("hold_chan", sif.out_chan, p_chan);
        check("hold_row", sif.out_row, p_row);
        check("hold_eoc", sif.out_eoc, p_eoc);
        check("hold_eof", sif.out_eof, p_eof);
      end
      check("data", sif.out_data, golden[c][r]);
      check("chan", sif.out_chan, c);
      check("row", sif.out_row, r);
      check("eoc", sif.out_eoc, (r == RO - 1));
      check("eof", sif.out_eof, (beat == NBEAT - 1));
      p_data = sif.out_data;
      p_chan = sif.out_chan;
      p_row  = sif.out_row;
      p_eoc  = sif.out_eoc;
      p_eof  = sif.out_eof;
      prev_stall = !sif.out_ready;
      if (sif.out_ready) beat++;
      tick();
      start = 1'b0;
      cyc++;
    end
    check("beats_before_timeout", beat, NBEAT);
    check("fin_done", done, 1);
    check("fin_valid", sif.out_valid, 0);
    check("fin_busy", busy, 0);
    start = poke_fin;
    tick();
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("idle_after_fin", sif.out_valid, 0);
    fmaps_in = golden;
  endtask

  typedef struct {
    logic rst, start, ready;
    logic e_valid, e_busy, e_done;
    int   e_row;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // reset/start/ready vectors from IDLE; expectations are post-edge values
    vecs[0] = '{rst:1, start:1, ready:0, e_valid:0, e_busy:0, e_done:0, e_row:0};
    vecs[1] = '{rst:0, start:0, ready:1, e_valid:0, e_busy:0, e_done:0, e_row:0};
    vecs[2] = '{rst:0, start:1, ready:0, e_valid:1, e_busy:1, e_done:0, e_row:0};
    vecs[3] = '{rst:0, start:0, ready:0, e_valid:1, e_busy:1, e_done:0, e_row:0};
    vecs[4] = '{rst:0, start:0, ready:1, e_valid:1, e_busy:1, e_done:0, e_row:1};
    vecs[5] = '{rst:1, start:0, ready:1, e_valid:0, e_busy:0, e_done:0, e_row:0};
    vecs[6] = '{rst:0, start:0, ready:1, e_valid:0, e_busy:0, e_done:0, e_row:0};

    rst = 1'b1;
    start = 1'b0;
    sif.out_ready = 1'b0;
    load_pattern();
    tick();
    tick();
    cur = "reset";
    check("valid", sif.out_valid, 0);
    check("busy", busy, 0);
    check("done", done, 0);
    check("data", sif.out_data, 0);
    check("chan", sif.out_chan, 0);
    check("row", sif.out_row, 0);
    check("eoc", sif.out_eoc, 0);
    check("eof", sif.out_eof, 0);

    cur = "vectors";
    for (int i = 0; i < 7; i++) begin
      rst = vecs[i].rst;
      start = vecs[i].start;
      sif.out_ready = vecs[i].ready;
      tick();
      check($sformatf("v%0d_valid", i), sif.out_valid, vecs[i].e_valid);
      check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("v%0d_done", i), done, vecs[i].e_done);
      check($sformatf("v%0d_row", i), sif.out_row, vecs[i].e_row);
    end
    rst = 1'b0;
    start = 1'b0;

    cur = "full_rate";
    run_frame(100, -1, 0, -1, 1'b0, 1'b0, -1);
    cur = "random_ready";
    run_frame(50, -1, 0, -1, 1'b0, 1'b0, -1);
    cur = "snapshot_and_pokes";
    run_frame(100, -1, 0, 40, 1'b1, 1'b1, -1);
    cur = "abort";
    run_frame(100, -1, 0, -1, 1'b0, 1'b0, 100);
    cur = "after_abort";
    run_frame(100, -1, 0, -1, 1'b0, 1'b0, -1);
    cur = "long_stall";
    run_frame(100, 11, 50, -1, 1'b0, 1'b0, -1);

    cur = "random_frame";
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < RO; r++)
        golden[c][r] = CO'($urandom());
    fmaps_in = golden;
    run_frame(70, -1, 0, -1, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
